// File: rtl/lbdr_pkg.sv
// Shared router definitions: flit types, port indices, arbiter states.
package lbdr_pkg;

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    localparam int P_N = 0;
    localparam int P_E = 1;
    localparam int P_W = 2;
    localparam int P_S = 3;
    localparam int P_L = 4;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/lbdr_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after last_winner.
module rr_pick #(
    parameter int NREQ = 5,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IW-1:0]   last_winner,
    output logic [NREQ-1:0] winner,
    output logic            any
);

    logic [IW-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_winner) + k) % NREQ);
            if (!any && eligible[idx]) begin
                winner[idx] = 1'b1;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lbdr_port_arbiter.sv
// Per-output packet arbiter with round-robin grant and downstream flow control.
// Define ARB_CREDIT_EN for a credit counter; otherwise credit_in is a ready level.
module lbdr_port_arbiter
    import lbdr_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int NREQ    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   valid,
    input  logic [3*NREQ-1:0] flit_id,
    input  logic              credit_in,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   rd_en,
    output logic              out_valid,
    output logic              busy,
    output logic [3:0]        credit_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (CREDITS < 1 || CREDITS > 15) begin : g_bad_credits
        $error("CREDITS must be in 1..15");
    end

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   lw_q, lw_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick_oh;
    logic            pick_any;
    logic [IW-1:0]   widx;
    logic [2:0]      gflit;
    logic            can_send;
    logic            fwd;
    logic            is_tail;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req[i] & valid[i]
                        & (flit_id[3*i +: 3] == HEADER);
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .eligible    (eligible),
        .last_winner (lw_q),
        .winner      (pick_oh),
        .any         (pick_any)
    );

    always_comb begin
        widx  = '0;
        gflit = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                widx  = IW'(i);
                gflit = flit_id[3*i +: 3];
            end
        end
    end

    // Pops are suppressed while reset is held so an abandoned packet loses nothing more.
    always_comb begin
        rd_en = '0;
        if (rst && state_q == LOCKED) begin
            rd_en = grant_q & valid & {NREQ{can_send}};
        end
    end

    assign fwd       = |rd_en;
    assign is_tail   = fwd && (gflit == TAIL);
    assign out_valid = fwd;
    assign grant     = grant_q;
    assign busy      = busy_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        lw_d    = lw_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = LOCKED;
                    grant_d = pick_oh;
                    busy_d  = 1'b1;
                end
            end
            LOCKED: begin
                if (is_tail) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    lw_d    = widx;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            lw_q    <= IW'(NREQ - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            lw_q    <= lw_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ARB_CREDIT_EN
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    logic [3:0] cnt_q, cnt_d;

    assign can_send   = (cnt_q != 4'd0);
    assign credit_cnt = cnt_q;

    // A pop and a returned credit in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (fwd && !credit_in) begin
            cnt_d = cnt_q - 4'd1;
        end else if (!fwd && credit_in && cnt_q != CRED_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= CRED_MAX;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign can_send   = credit_in;
    assign credit_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_lbdr_port_arbiter.sv
// Scoreboard bench for lbdr_port_arbiter; covers credit and ready builds.
module tb_lbdr_port_arbiter;
    import lbdr_pkg::*;

    localparam int NREQ    = 5;
    localparam int CREDITS = 4;
`ifdef ARB_CREDIT_EN
    localparam int RST_CNT = CREDITS;
    localparam int STALL_N = 4;
`else
    localparam int RST_CNT = 0;
    localparam int STALL_N = 2;
`endif

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   valid;
    logic [3*NREQ-1:0] flit_id;
    logic              credit_in;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   rd_en;
    logic              out_valid;
    logic              busy;
    logic [3:0]        credit_cnt;

    lbdr_port_arbiter #(
        .CREDITS (CREDITS),
        .NREQ    (NREQ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .valid      (valid),
        .flit_id    (flit_id),
        .credit_in  (credit_in),
        .grant      (grant),
        .rd_en      (rd_en),
        .out_valid  (out_valid),
        .busy       (busy),
        .credit_cnt (credit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int pops0;

    logic [2:0]      fq[NREQ][$];
    int              sb_q[$];
    logic [NREQ-1:0] pend;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NREQ; i++) begin
            valid[i] = (fq[i].size() != 0);
            flit_id[3*i +: 3] = valid[i] ? fq[i][0] : 3'b000;
        end
    endtask

    task automatic load_fifo(input int p, input int n);
        fq[p].push_back(HEADER);
        for (int j = 0; j < n - 2; j++) fq[p].push_back(PAYLOAD);
        fq[p].push_back(TAIL);
    endtask

    task automatic expect_pkt(input int p, input int n);
        for (int j = 0; j < n; j++) sb_q.push_back(p);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        int exp_p;
        pend = rd_en;
        if (rd_en != '0) begin
            pops++;
            if (sb_q.size() == 0) begin
                check("spurious_pop", 32'(rd_en), 32'd0);
            end else begin
                exp_p = sb_q.pop_front();
                check("rd_en", 32'(rd_en), 32'd1 << exp_p);
                check("out_valid", 32'(out_valid), 32'd1);
            end
        end else begin
            check("out_valid_idle", 32'(out_valid), 32'd0);
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        end
        pend = '0;
        refresh();
    end

    logic [4:0] rr_exp [12];

    initial begin
        rr_exp = '{5'b00001, 5'b00001, 5'b00000, 5'b00100, 5'b00100, 5'b00000,
                   5'b00001, 5'b00001, 5'b00000, 5'b00100, 5'b00100, 5'b00000};
        pend = '0;
        rst = 1'b0;
        req = '0;
        credit_in = 1'b0;
        refresh();
        repeat (3) tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(credit_cnt), 32'(RST_CNT));
        rst = 1'b1;
        tick();

        // single packet on E
`ifdef ARB_CREDIT_EN
        credit_in = 1'b0;
`else
        credit_in = 1'b1;
`endif
        pops0 = pops;
        load_fifo(P_E, 3);
        expect_pkt(P_E, 3);
        req = 5'b00010;
        refresh();
        tick();
        check("t1_grant", 32'(grant), 32'b00010);
        check("t1_busy", 32'(busy), 32'd1);
        tick();
        tick();
        check("t1_hold", 32'(grant), 32'b00010);
        tick();
        check("t1_release", 32'(grant), 32'd0);
        check("t1_busy_off", 32'(busy), 32'd0);
        check("t1_pops", 32'(pops - pops0), 32'd3);
`ifdef ARB_CREDIT_EN
        check("t1_cnt", 32'(credit_cnt), 32'd1);
`endif
        req = '0;

`ifdef ARB_CREDIT_EN
        credit_in = 1'b1;
        repeat (3) tick();
        credit_in = 1'b0;
        check("cred_return", 32'(credit_cnt), 32'(CREDITS));
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check("cred_sat", 32'(credit_cnt), 32'(CREDITS));
`endif

        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // round robin between N and W
        credit_in = 1'b1;
        load_fifo(P_N, 2);
        load_fifo(P_N, 2);
        load_fifo(P_W, 2);
        load_fifo(P_W, 2);
        expect_pkt(P_N, 2);
        expect_pkt(P_W, 2);
        expect_pkt(P_N, 2);
        expect_pkt(P_W, 2);
        req = 5'b00101;
        refresh();
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("rr_grant%0d", i), 32'(grant), 32'(rr_exp[i]));
        end
        check("rr_cnt", 32'(credit_cnt), 32'(RST_CNT));
        req = '0;

        // reset in the middle of a W packet
`ifdef ARB_CREDIT_EN
        credit_in = 1'b0;
`endif
        pops0 = pops;
        load_fifo(P_W, 4);
        expect_pkt(P_W, 2);
        req = 5'b00100;
        refresh();
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("mid_grant", 32'(grant), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_cnt", 32'(credit_cnt), 32'(RST_CNT));
        check("mid_pops", 32'(pops - pops0), 32'd2);
        rst = 1'b1;
        fq[P_W].delete();
        req = '0;
        refresh();
        tick();

        // N must win over S after reset
        credit_in = 1'b1;
        load_fifo(P_N, 2);
        load_fifo(P_S, 2);
        expect_pkt(P_N, 2);
        expect_pkt(P_S, 2);
        req = 5'b01001;
        refresh();
        tick();
        check("prio_grant", 32'(grant), 32'b00001);
        repeat (3) tick();
        check("prio_second", 32'(grant), 32'b01000);
        repeat (2) tick();
        check("prio_done", 32'(grant), 32'd0);
        req = '0;

`ifdef ARB_CREDIT_EN
        credit_in = 1'b0;
        load_fifo(P_L, 3);
        expect_pkt(P_L, 3);
        req = 5'b10000;
        refresh();
        tick();
        tick();
        check("pre_simul_cnt", 32'(credit_cnt), 32'd3);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check("simul_cnt", 32'(credit_cnt), 32'd3);
        tick();
        check("post_simul_cnt", 32'(credit_cnt), 32'd2);
        check("post_simul_grant", 32'(grant), 32'd0);
        req = '0;
        credit_in = 1'b1;
        repeat (2) tick();
`endif

        // lock: L header must wait for E tail
        load_fifo(P_E, 4);
        expect_pkt(P_E, 4);
        expect_pkt(P_L, 2);
        req = 5'b00010;
        refresh();
        tick();
        check("lock_grant", 32'(grant), 32'b00010);
        load_fifo(P_L, 2);
        req = 5'b10010;
        refresh();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("lock_hold%0d", i), 32'(grant), 32'b00010);
        end
        tick();
        check("lock_gap", 32'(grant), 32'd0);
        tick();
        check("lock_next", 32'(grant), 32'b10000);
        repeat (2) tick();
        req = '0;

        // non-header head flit is ignored
        fq[P_S].push_back(PAYLOAD);
        req = 5'b01000;
        refresh();
        repeat (3) tick();
        check("nohdr_grant", 32'(grant), 32'd0);
        check("nohdr_busy", 32'(busy), 32'd0);
        fq[P_S].delete();
        req = '0;
        refresh();
        tick();

        // downstream stall with grant held
        pops0 = pops;
        load_fifo(P_S, STALL_N + 2);
        expect_pkt(P_S, STALL_N + 2);
        req = 5'b01000;
`ifdef ARB_CREDIT_EN
        credit_in = 1'b0;
        refresh();
        repeat (7) tick();
`else
        refresh();
        repeat (3) tick();
        credit_in = 1'b0;
        repeat (3) tick();
`endif
        check("stall_pops", 32'(pops - pops0), 32'(STALL_N));
        check("stall_grant", 32'(grant), 32'b01000);
        check("stall_busy", 32'(busy), 32'd1);
`ifdef ARB_CREDIT_EN
        check("stall_cnt", 32'(credit_cnt), 32'd0);
`endif
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        repeat (2) tick();
        check("stall_one_more", 32'(pops - pops0), 32'(STALL_N + 1));
        check("stall_grant2", 32'(grant), 32'b01000);
        credit_in = 1'b1;
        repeat (4) tick();
        check("stall_done", 32'(grant), 32'd0);
        check("stall_total", 32'(pops - pops0), 32'(STALL_N + 2));
        req = '0;

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
